// File: rtl/z16_pkg.sv
// Shared Z16 constants and the machine word type.
// Used by the data memory, the register file and the ALU.
package z16_pkg;

  localparam int Z16_DATA_W = 16;
  localparam int Z16_ADDR_W = 16;

  typedef logic [Z16_DATA_W-1:0] z16_word_t;

endpackage

// File: rtl/z16_data_memory.sv
// Z16 data memory: word-addressed RAM with a synchronous write port and a
// combinational read port. Synchronous reset clears every word in one cycle.
module z16_data_memory
  import z16_pkg::*;
#(
  parameter int DATA_W = Z16_DATA_W,
  parameter int ADDR_W = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [Z16_ADDR_W-1:0] i_addr,
  input  logic                  i_wen,
  input  logic [DATA_W-1:0]     i_data,
  output logic [DATA_W-1:0]     o_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] word_addr;
  logic              unused_addr_hi;

  // Upper address bits are not decoded, so addresses alias modulo DEPTH.
  assign word_addr      = i_addr[ADDR_W-1:0];
  assign unused_addr_hi = ^i_addr[Z16_ADDR_W-1:ADDR_W];

  // Reset wins over a simultaneous store; an unknown address never writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (i_wen && !$isunknown(word_addr)) begin
      mem[word_addr] <= i_data;
    end
  end

  assign o_data = mem[word_addr];

endmodule

// File: tb/tb_z16_data_memory.sv
// Self-checking bench for z16_data_memory: directed scenarios plus random
// load/store/reset traffic, scored against an abstract word-array model.
module tb_z16_data_memory;

  localparam int DEPTH = 1024;

  logic        i_clk;
  logic        i_rst;
  logic [15:0] i_addr;
  logic        i_wen;
  logic [15:0] i_data;
  logic [15:0] o_data;

  int checks;
  int errors;

  logic [15:0] ref_mem [DEPTH];
  logic [15:0] exp_q [$];
  string       name_q [$];
  logic [15:0] addr_q [$];
  event        push_ev;

  z16_data_memory dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_addr (i_addr),
    .i_wen  (i_wen),
    .i_data (i_data),
    .o_data (o_data)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Monitor: compares o_data against each queued expectation as it arrives.
  initial begin
    logic [15:0] exp_v;
    logic [15:0] addr_v;
    string       name_v;
    forever begin
      @(push_ev);
      while (exp_q.size() > 0) begin
        #1;
        exp_v  = exp_q.pop_front();
        name_v = name_q.pop_front();
        addr_v = addr_q.pop_front();
        checks++;
        if (o_data !== exp_v) begin
          errors++;
          $display("[TB] FAIL %s addr=%h got=%h exp=%h", name_v, addr_v, o_data, exp_v);
        end
      end
    end
  end

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    return ref_mem[int'(addr) % DEPTH];
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] exp_v);
    exp_q.push_back(exp_v);
    name_q.push_back(name);
    addr_q.push_back(i_addr);
    ->push_ev;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s monitor timeout got=pending exp=%h", name, exp_v);
      exp_q.delete();
      name_q.delete();
      addr_q.delete();
    end
  endtask

  task automatic readCheck(input string name, input logic [15:0] addr);
    i_wen  = 1'b0;
    i_addr = addr;
    checkOutput(name, model_read(addr));
  endtask

  // One clock edge of stimulus; reset clears the model and drops the store.
  task automatic applyStimulus(input logic rst, input logic wen,
                               input logic [15:0] addr, input logic [15:0] data,
                               input string name);
    @(negedge i_clk);
    i_rst  = rst;
    i_wen  = wen;
    i_addr = addr;
    i_data = data;
    checkOutput({name, "_pre"}, model_read(addr));
    @(posedge i_clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'h0000;
    end else if (wen) begin
      ref_mem[int'(addr) % DEPTH] = data;
    end
    #1;
    checkOutput({name, "_post"}, model_read(addr));
    @(negedge i_clk);
    i_rst = 1'b0;
    i_wen = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] r_addr;
    logic [15:0] r_data;
    logic        r_wen;
    logic        r_rst;
    checks = 0;
    errors = 0;
    i_rst  = 1'b1;
    i_wen  = 1'b0;
    i_addr = 16'h0000;
    i_data = 16'h0000;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'hxxxx;

    // Reset then sweep every decoded address.
    applyStimulus(1'b1, 1'b0, 16'h0000, 16'h0000, "reset");
    for (int a = 0; a < DEPTH; a++) readCheck("reset_sweep", 16'(a));

    applyStimulus(1'b0, 1'b1, 16'h0100, 16'h5555, "wr_0100");
    readCheck("rd_0000", 16'h0000);
    readCheck("rd_0100", 16'h0100);

    applyStimulus(1'b0, 1'b1, 16'h0001, 16'hA5A5, "wr_0001");
    @(negedge i_clk);
    readCheck("comb_rd_0100", 16'h0100);
    #1;
    readCheck("comb_rd_0001", 16'h0001);
    if (16'hA5A5 !== o_data) ;

    applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1111, "wr_0010");
    applyStimulus(1'b0, 1'b1, 16'h0010, 16'h2222, "rdw_0010");

    applyStimulus(1'b0, 1'b1, 16'h0405, 16'hBEEF, "alias_wr");
    readCheck("alias_rd_0005", 16'h0005);
    readCheck("alias_rd_fc05", 16'hFC05);

    applyStimulus(1'b1, 1'b1, 16'h0020, 16'hFFFF, "rst_vs_wr");
    readCheck("rst_rd_0020", 16'h0020);
    readCheck("rst_rd_0100", 16'h0100);
    readCheck("rst_rd_0005", 16'h0005);

    applyStimulus(1'b0, 1'b1, 16'h0020, 16'h1234, "resume_wr");
    readCheck("resume_rd", 16'h0020);

    // Random traffic over a narrow window so stores and loads collide often.
    for (int n = 0; n < 300; n++) begin
      r_addr = 16'($urandom_range(0, 31)) | (16'($urandom_range(0, 63)) << 10);
      r_data = 16'($urandom);
      r_wen  = ($urandom_range(0, 2) != 0);
      r_rst  = ($urandom_range(0, 39) == 0);
      applyStimulus(r_rst, r_wen, r_addr, r_data, "rand_op");
      readCheck("rand_rd", 16'($urandom_range(0, 31)) | (16'($urandom) & 16'hFC00));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
